vx_gpr_fetch: RTL and testbench

VX_GPR_FETCH -- requirements
Module: VX_gpr_fetch

---
 rtl/vx_gpr_fetch.sv | 165 ++++++++++++++++
 tb/tb_vx_gpr_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_gpr_fetch.sv
// Operand fetch stage: issues register-file reads, merges same-cycle writeback
// forwarding and zero-register handling, and buffers operands in a 2-entry FIFO.
module vx_gpr_fetch #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_WARPS   = 4,
  parameter int METAW       = 8,
  parameter int WIDW        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [WIDW-1:0]          in_wid_i,
  input  logic [NUM_THREADS-1:0]   in_tmask_i,
  input  logic [4:0]               in_rs1_i,
  input  logic [4:0]               in_rs2_i,
  input  logic [4:0]               in_rs3_i,
  input  logic [METAW-1:0]         in_meta_i,
  output logic [WIDW-1:0]          gpr_req_wid_o,
  output logic [4:0]               gpr_req_rs1_o,
  output logic [4:0]               gpr_req_rs2_o,
  output logic [4:0]               gpr_req_rs3_o,
  input  logic [NUM_THREADS*32-1:0] gpr_rsp_rs1_data_i,
  input  logic [NUM_THREADS*32-1:0] gpr_rsp_rs2_data_i,
  input  logic [NUM_THREADS*32-1:0] gpr_rsp_rs3_data_i,
  input  logic                     wb_valid_i,
  input  logic [WIDW-1:0]          wb_wid_i,
  input  logic [4:0]               wb_rd_i,
  input  logic [NUM_THREADS-1:0]   wb_tmask_i,
  input  logic [NUM_THREADS*32-1:0] wb_data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [WIDW-1:0]          out_wid_o,
  output logic [NUM_THREADS-1:0]   out_tmask_o,
  output logic [METAW-1:0]         out_meta_o,
  output logic [NUM_THREADS*32-1:0] out_rs1_data_o,
  output logic [NUM_THREADS*32-1:0] out_rs2_data_o,
  output logic [NUM_THREADS*32-1:0] out_rs3_data_o
);

  logic in_fire;
  logic out_fire;
  logic push;
  logic wb_hit;
  logic [2:0] occ;

  logic [4:0]                src_rs   [3];
  logic [NUM_THREADS*32-1:0] rsp_data [3];
  logic [NUM_THREADS-1:0]    fwd_mask [3];
  logic [NUM_THREADS*32-1:0] cap_data [3];

  // request-to-response stage
  logic                      inflight_q;
  logic [WIDW-1:0]           st_wid_q;
  logic [NUM_THREADS-1:0]    st_tmask_q;
  logic [METAW-1:0]          st_meta_q;
  logic [2:0]                st_zero_q;
  logic [NUM_THREADS-1:0]    st_fwd_q [3];
  logic [NUM_THREADS*32-1:0] st_wb_data_q;

  // output FIFO
  logic [WIDW-1:0]           fifo_wid_q   [2];
  logic [NUM_THREADS-1:0]    fifo_tmask_q [2];
  logic [METAW-1:0]          fifo_meta_q  [2];
  logic [NUM_THREADS*32-1:0] fifo_data_q  [2][3];
  logic                      wr_ptr_q;
  logic                      rd_ptr_q;
  logic [1:0]                count_q;
  logic [1:0]                count_d;

  assign gpr_req_wid_o = in_wid_i;
  assign gpr_req_rs1_o = in_rs1_i;
  assign gpr_req_rs2_o = in_rs2_i;
  assign gpr_req_rs3_o = in_rs3_i;

  assign src_rs[0]   = in_rs1_i;
  assign src_rs[1]   = in_rs2_i;
  assign src_rs[2]   = in_rs3_i;
  assign rsp_data[0] = gpr_rsp_rs1_data_i;
  assign rsp_data[1] = gpr_rsp_rs2_data_i;
  assign rsp_data[2] = gpr_rsp_rs3_data_i;

  assign out_valid_o = (count_q != 2'd0);
  assign out_fire    = out_valid_o & out_ready_i;
  // Credit covers both buffered entries and the response still on its way.
  assign occ         = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, out_fire};
  assign in_ready_o  = (occ < 3'd2);
  assign in_fire     = in_valid_i & in_ready_o;
  assign push        = inflight_q;

  assign wb_hit = wb_valid_i && (wb_rd_i != 5'd0) && (wb_wid_i == in_wid_i);

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      fwd_mask[s] = '0;
      if (wb_hit && (wb_rd_i == src_rs[s])) fwd_mask[s] = wb_tmask_i;
    end
  end

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      cap_data[s] = rsp_data[s];
      for (int l = 0; l < NUM_THREADS; l++) begin
        if (st_zero_q[s])       cap_data[s][l*32 +: 32] = 32'h0;
        else if (st_fwd_q[s][l]) cap_data[s][l*32 +: 32] = st_wb_data_q[l*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) inflight_q <= 1'b0;
    else         inflight_q <= in_fire;
  end

  always_ff @(posedge clk_i) begin
    if (in_fire) begin
      st_wid_q     <= in_wid_i;
      st_tmask_q   <= in_tmask_i;
      st_meta_q    <= in_meta_i;
      st_wb_data_q <= wb_data_i;
      for (int s = 0; s < 3; s++) begin
        st_zero_q[s] <= (src_rs[s] == 5'd0);
        st_fwd_q[s]  <= fwd_mask[s];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, out_fire})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (out_fire) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      fifo_wid_q[wr_ptr_q]   <= st_wid_q;
      fifo_tmask_q[wr_ptr_q] <= st_tmask_q;
      fifo_meta_q[wr_ptr_q]  <= st_meta_q;
      for (int s = 0; s < 3; s++) fifo_data_q[wr_ptr_q][s] <= cap_data[s];
    end
  end

  assign out_wid_o      = fifo_wid_q[rd_ptr_q];
  assign out_tmask_o    = fifo_tmask_q[rd_ptr_q];
  assign out_meta_o     = fifo_meta_q[rd_ptr_q];
  assign out_rs1_data_o = fifo_data_q[rd_ptr_q][0];
  assign out_rs2_data_o = fifo_data_q[rd_ptr_q][1];
  assign out_rs3_data_o = fifo_data_q[rd_ptr_q][2];

endmodule

// File: tb/tb_vx_gpr_fetch.sv
// Scoreboard bench for vx_gpr_fetch: expected operands are built from the
// forwarding/zero rules at issue time and checked by an independent monitor.
module tb_vx_gpr_fetch;
  localparam int NT = 4, NW = 4, MW = 8, WW = 2, DW = NT*32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_ready;
  logic [WW-1:0] in_wid = '0;
  logic [NT-1:0] in_tmask = '0;
  logic [4:0]    in_rs1 = '0, in_rs2 = '0, in_rs3 = '0;
  logic [MW-1:0] in_meta = '0;
  logic [WW-1:0] req_wid;
  logic [4:0]    req_rs1, req_rs2, req_rs3;
  logic [DW-1:0] rsp1 = '0, rsp2 = '0, rsp3 = '0;
  logic          wb_valid = 1'b0;
  logic [WW-1:0] wb_wid = '0;
  logic [4:0]    wb_rd = '0;
  logic [NT-1:0] wb_tmask = '0;
  logic [DW-1:0] wb_data = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [WW-1:0] out_wid;
  logic [NT-1:0] out_tmask;
  logic [MW-1:0] out_meta;
  logic [DW-1:0] out_d1, out_d2, out_d3;

  vx_gpr_fetch #(.NUM_THREADS(NT), .NUM_WARPS(NW), .METAW(MW)) dut (
    .clk_i(clk), .reset_i(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_wid_i(in_wid), .in_tmask_i(in_tmask),
    .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_rs3_i(in_rs3), .in_meta_i(in_meta),
    .gpr_req_wid_o(req_wid), .gpr_req_rs1_o(req_rs1), .gpr_req_rs2_o(req_rs2), .gpr_req_rs3_o(req_rs3),
    .gpr_rsp_rs1_data_i(rsp1), .gpr_rsp_rs2_data_i(rsp2), .gpr_rsp_rs3_data_i(rsp3),
    .wb_valid_i(wb_valid), .wb_wid_i(wb_wid), .wb_rd_i(wb_rd), .wb_tmask_i(wb_tmask), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_wid_o(out_wid), .out_tmask_o(out_tmask), .out_meta_o(out_meta),
    .out_rs1_data_o(out_d1), .out_rs2_data_o(out_d2), .out_rs3_data_o(out_d3)
  );

  typedef struct packed {
    logic [WW-1:0] wid;
    logic [NT-1:0] tmask;
    logic [MW-1:0] meta;
    logic [DW-1:0] d1, d2, d3;
  } exp_t;

  exp_t sb[$];
  exp_t mon_act;
  int   n_checks = 0;
  int   n_fail = 0;
  logic pending = 1'b0;
  logic [DW-1:0] pend1, pend2, pend3;
  logic fixed_en = 1'b0;
  logic [DW-1:0] fix1 = '0, fix2 = '0, fix3 = '0;

  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int l = 0; l < NT; l++) r[l*32 +: 32] = $urandom;
    return r;
  endfunction

  // Expected operand of one source given the data the register file will return.
  function automatic logic [DW-1:0] exp_src(logic [4:0] rs, logic [DW-1:0] rsp);
    logic [DW-1:0] r;
    if (rs == 5'd0) return '0;
    r = rsp;
    if (wb_valid && wb_rd != 5'd0 && wb_wid == in_wid && wb_rd == rs)
      for (int l = 0; l < NT; l++)
        if (wb_tmask[l]) r[l*32 +: 32] = wb_data[l*32 +: 32];
    return r;
  endfunction

  task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: record an issue at the negedge, then present the register-file
  // response one cycle later (random filler when nothing was issued).
  task automatic step();
    logic was_reset;
    @(negedge clk);
    was_reset = reset;
    if (!reset && in_valid && in_ready) begin
      pend1 = fixed_en ? fix1 : rnd();
      pend2 = fixed_en ? fix2 : rnd();
      pend3 = fixed_en ? fix3 : rnd();
      sb.push_back({in_wid, in_tmask, in_meta,
                    exp_src(in_rs1, pend1), exp_src(in_rs2, pend2), exp_src(in_rs3, pend3)});
      pending = 1'b1;
    end else begin
      pending = 1'b0;
    end
    @(posedge clk);
    #1;
    if (was_reset) sb.delete();
    rsp1 = pending ? pend1 : rnd();
    rsp2 = pending ? pend2 : rnd();
    rsp3 = pending ? pend3 : rnd();
  endtask

  task automatic rand_inputs(int p_valid, int p_ready);
    in_valid  = (int'($urandom_range(99)) < p_valid);
    in_wid    = WW'($urandom);
    in_tmask  = NT'($urandom);
    in_rs1    = 5'($urandom_range(7));
    in_rs2    = 5'($urandom_range(7));
    in_rs3    = 5'($urandom_range(7));
    in_meta   = MW'($urandom);
    wb_valid  = 1'($urandom_range(1));
    wb_wid    = WW'($urandom);
    wb_rd     = 5'($urandom_range(7));
    wb_tmask  = NT'($urandom);
    wb_data   = rnd();
    out_ready = (int'($urandom_range(99)) < p_ready);
  endtask

  task automatic drain(int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (n) step();
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      mon_act = {out_wid, out_tmask, out_meta, out_d1, out_d2, out_d3};
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %h expected nothing", mon_act);
      end else begin
        if (mon_act !== sb[0]) begin
          n_fail++;
          $display("FAIL out_data: got %h expected %h", mon_act, sb[0]);
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    reset = 1'b1;
    step();
    step();
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(1));
    reset = 1'b0;
    out_ready = 1'b1;

    // single issue, fixed response data, 2-cycle latency
    in_valid = 1'b1; in_wid = 2'd1; in_tmask = '1; in_meta = 8'h5A;
    in_rs1 = 5'd3; in_rs2 = 5'd4; in_rs3 = 5'd0; wb_valid = 1'b0;
    fixed_en = 1'b1; fix1 = {4{32'h11}}; fix2 = {4{32'h22}}; fix3 = rnd();
    step();
    in_valid = 1'b0;
    check("lat_n1_out_valid", DW'(out_valid), DW'(0));
    step();
    check("lat_n2_out_valid", DW'(out_valid), DW'(1));
    check("single_rs1", out_d1, {4{32'h11}});
    check("single_rs2", out_d2, {4{32'h22}});
    check("single_wid", DW'(out_wid), DW'(1));
    check("single_meta", DW'(out_meta), DW'(8'h5A));
    fixed_en = 1'b0;
    drain(3);

    // back-to-back: 8 issues, 8 consecutive outputs
    for (int k = 0; k < 10; k++) begin
      if (k < 8) rand_inputs(100, 100);
      else in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      if (k < 8) check("b2b_in_ready", DW'(in_ready), DW'(1));
      if (k >= 2) check("b2b_out_valid", DW'(out_valid), DW'(1));
      step();
    end
    drain(3);

    // backpressure: two accepted, then stalled until out_ready rises
    for (int k = 0; k < 6; k++) begin
      rand_inputs(100, 0);
      in_valid = 1'b1;
      out_ready = (k == 5);
      #1;
      check("bp_in_ready", DW'(in_ready), DW'((k < 2) || (k == 5)));
      step();
    end
    drain(4);

    // forwarding hit: lanes 0 and 2 from writeback
    rand_inputs(100, 100);
    in_valid = 1'b1; in_wid = 2'd2; in_rs1 = 5'd5; in_rs2 = 5'd6; in_rs3 = 5'd7;
    wb_valid = 1'b1; wb_wid = 2'd2; wb_rd = 5'd5; wb_tmask = 4'b0101; wb_data = {4{32'hAAAAAAAA}};
    fixed_en = 1'b1; fix1 = {4{32'h12345678}}; fix2 = rnd(); fix3 = rnd();
    step();
    in_valid = 1'b0;
    step();
    check("fwd_hit_rs1", out_d1, {32'h12345678, 32'hAAAAAAAA, 32'h12345678, 32'hAAAAAAAA});
    // other warp: no forwarding
    in_valid = 1'b1; wb_wid = 2'd3;
    step();
    in_valid = 1'b0;
    step();
    check("fwd_miss_rs1", out_d1, {4{32'h12345678}});
    // zero register ignores response and writeback
    in_valid = 1'b1; in_rs2 = 5'd0; wb_wid = in_wid; wb_rd = 5'd0; wb_tmask = '1;
    fix2 = {4{32'hDEADBEEF}};
    step();
    in_valid = 1'b0;
    step();
    check("zero_rs2", out_d2, '0);
    fixed_en = 1'b0;
    drain(3);

    // reset with one buffered and one in flight
    for (int k = 0; k < 2; k++) begin
      rand_inputs(100, 0);
      in_valid = 1'b1;
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("midrst_out_valid", DW'(out_valid), DW'(0));
    check("midrst_in_ready", DW'(in_ready), DW'(1));
    rand_inputs(100, 100);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("midrst_n1_out_valid", DW'(out_valid), DW'(0));
    step();
    check("midrst_n2_out_valid", DW'(out_valid), DW'(1));
    drain(3);

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      rand_inputs(70, 60);
      reset = (int'($urandom_range(299)) == 0);
      step();
    end
    reset = 1'b0;

    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      step();
      guard++;
    end
    check("drain_empty", DW'(sb.size()), DW'(0));
    step();
    check("final_out_valid", DW'(out_valid), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
